// File: rtl/odo_sbox_inv_loader.sv
// Runtime-loadable inverse S-box: takes a forward table in index order, builds its inverse, serves 1-cycle lookups.
// Define ODO_SBOX_INV_CHECK_EN to build the bijection check (seen bitmap, dup flag, load_error).
module odo_sbox_inv_loader #(
  parameter int unsigned W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         restart_i,
  input  logic         load_valid_i,
  input  logic [W-1:0] load_data_i,
  output logic         load_ready_o,
  output logic         load_done_o,
  output logic         load_error_o,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_o
);

  localparam int unsigned DEPTH    = 1 << W;
  localparam logic [W:0]  LAST_IDX = (W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W:0]   idx_q, idx_d;
  logic         done_q, done_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_q, out_d;
  logic         inv_we_c;
  logic [W-1:0] inv_q [DEPTH];

`ifdef ODO_SBOX_INV_CHECK_EN
  logic [DEPTH-1:0] seen_q, seen_d;
  logic             dup_q, dup_d;
  logic             error_q, error_d;
  logic             dup_now_c;
`endif

  // Next-state, table-write enable and lookup result
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    out_d       = out_q;
    inv_we_c    = 1'b0;
`ifdef ODO_SBOX_INV_CHECK_EN
    seen_d      = seen_q;
    dup_d       = dup_q;
    error_d     = error_q;
    dup_now_c   = dup_q | seen_q[load_data_i];
`endif
    if (restart_i) begin
      state_d = ST_LOAD;
      idx_d   = '0;
`ifdef ODO_SBOX_INV_CHECK_EN
      seen_d  = '0;
      dup_d   = 1'b0;
      error_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_valid_i) begin
            inv_we_c = 1'b1;
            idx_d    = idx_q + (W+1)'(1);
`ifdef ODO_SBOX_INV_CHECK_EN
            seen_d[load_data_i] = 1'b1;
            dup_d               = dup_now_c;
            if (idx_q == LAST_IDX) begin
              if (dup_now_c) begin
                state_d = ST_ERR;
                error_d = 1'b1;
              end else begin
                state_d = ST_READY;
                done_d  = 1'b1;
              end
            end
`else
            if (idx_q == LAST_IDX) begin
              state_d = ST_READY;
              done_d  = 1'b1;
            end
`endif
          end
        end
        ST_READY: begin
          if (in_valid_i) begin
            out_valid_d = 1'b1;
            out_d       = inv_q[in_i];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef ODO_SBOX_INV_CHECK_EN
      seen_q      <= '0;
      dup_q       <= 1'b0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
`ifdef ODO_SBOX_INV_CHECK_EN
      seen_q      <= seen_d;
      dup_q       <= dup_d;
      error_q     <= error_d;
`endif
    end
  end

  // Table storage is never cleared; it is only meaningful once READY
  always_ff @(posedge clk_i) begin
    if (inv_we_c && !rst_i) begin
      inv_q[load_data_i] <= idx_q[W-1:0];
    end
  end

  assign load_ready_o = (state_q == ST_LOAD);
  assign load_done_o  = done_q;
  assign out_valid_o  = out_valid_q;
  assign out_o        = out_q;
`ifdef ODO_SBOX_INV_CHECK_EN
  assign load_error_o = error_q;
`else
  assign load_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_odo_sbox_inv_loader.sv
// Directed + randomized bench for odo_sbox_inv_loader against an array-based inverse-table model.
module tb_odo_sbox_inv_loader;

  localparam int unsigned W = 6;
  localparam int unsigned N = 64;
`ifdef ODO_SBOX_INV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, restart, load_valid, in_valid;
  logic [W-1:0] load_data, in_sym;
  logic         load_ready, load_done, load_error, out_valid;
  logic [W-1:0] out_sym;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [W-1:0] fwd_m [N];
  logic [W-1:0] inv_m [N];
  bit           exp_err;
  logic [W-1:0] exp_out;

  odo_sbox_inv_loader #(.W(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .restart_i    (restart),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .load_done_o  (load_done),
    .load_error_o (load_error),
    .in_valid_i   (in_valid),
    .in_i         (in_sym),
    .out_valid_o  (out_valid),
    .out_o        (out_sym)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inverse of the forward table (later index wins) and bijection test by value counting
  function automatic void build_model();
    int cnt [N];
    bit bij;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < N; i++) begin
      inv_m[fwd_m[i]] = W'(i);
      cnt[fwd_m[i]]++;
    end
    bij = 1'b1;
    for (int i = 0; i < N; i++) if (cnt[i] != 1) bij = 1'b0;
    exp_err = CHK && !bij;
  endfunction

  function automatic void shuffle_table();
    for (int i = 0; i < N; i++) fwd_m[i] = W'(i);
    for (int i = N - 1; i > 0; i--) begin
      int j;
      logic [W-1:0] t;
      j = int'($urandom_range(i, 0));
      t = fwd_m[i];
      fwd_m[i] = fwd_m[j];
      fwd_m[j] = t;
    end
  endfunction

  task automatic load_range(input bit gaps, input int first, input int last);
    for (int i = first; i < last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(3, 0)) begin
          load_valid = 1'b0;
          load_data  = W'($urandom);
          tick();
        end
      end
      load_valid = 1'b1;
      load_data  = fwd_m[i];
      chk1("ready_during_load", load_ready, 1'b1);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic check_complete(input string tag);
    chk1({tag, "_done"},  load_done,  !exp_err);
    chk1({tag, "_error"}, load_error, exp_err);
    chk1({tag, "_ready"}, load_ready, 1'b0);
  endtask

  task automatic lookup_step(input logic [W-1:0] a, input bit v, input bit ready);
    in_valid = v;
    in_sym   = a;
    tick();
    if (v && ready) exp_out = inv_m[a];
    chk1("lookup_valid", out_valid, v && ready);
    chkw("lookup_out",   out_sym,   exp_out);
  endtask

  task automatic do_restart(input bit with_lookup);
    restart    = 1'b1;
    load_valid = 1'b1;
    load_data  = W'($urandom);
    in_valid   = with_lookup;
    in_sym     = W'($urandom);
    tick();
    restart    = 1'b0;
    load_valid = 1'b0;
    in_valid   = 1'b0;
    chk1("restart_ready",     load_ready, 1'b1);
    chk1("restart_done",      load_done,  1'b0);
    chk1("restart_error",     load_error, 1'b0);
    chk1("restart_out_valid", out_valid,  1'b0);
    chkw("restart_out_hold",  out_sym,    exp_out);
  endtask

  initial begin
    logic [W-1:0] seq [3];
    rst = 1'b1; restart = 1'b0; load_valid = 1'b0; load_data = '0;
    in_valid = 1'b0; in_sym = '0; exp_out = '0;
    tick(); tick();
    rst = 1'b0;
    chk1("rst_ready", load_ready, 1'b1);
    chk1("rst_done",  load_done,  1'b0);
    chk1("rst_error", load_error, 1'b0);
    chk1("rst_ovld",  out_valid,  1'b0);
    chkw("rst_out",   out_sym,    '0);

    // Identity table, back-to-back accepts
    for (int i = 0; i < N; i++) fwd_m[i] = W'(i);
    build_model();
    load_range(1'b0, 0, N);
    check_complete("ident");
    lookup_step(6'h2A, 1'b1, 1'b1);
    chk1("ident_done_pulse", load_done, 1'b0);
    lookup_step(6'h00, 1'b0, 1'b1);

    // Restart after 10 identity accepts, then XOR-0x15 table with gaps
    do_restart(1'b1);
    load_range(1'b0, 0, 10);
    do_restart(1'b0);
    for (int i = 0; i < N; i++) fwd_m[i] = W'(i) ^ W'(6'h15);
    build_model();
    load_range(1'b1, 0, N - 1);
    chk1("xor_not_done_63", load_done,  1'b0);
    chk1("xor_ready_63",    load_ready, 1'b1);
    load_range(1'b1, N - 1, N);
    check_complete("xor");
    seq[0] = 6'h00; seq[1] = 6'h3F; seq[2] = 6'h15;
    for (int k = 0; k < 3; k++) lookup_step(seq[k], 1'b1, 1'b1);
    chkw("xor_last_value", out_sym, 6'h00);
    lookup_step(6'h00, 1'b0, 1'b1);

    // Identity with duplicate at index 5
    do_restart(1'b1);
    for (int i = 0; i < N; i++) fwd_m[i] = W'(i);
    fwd_m[5] = 6'h03;
    build_model();
    load_range(1'b0, 0, N);
    check_complete("dup");
    repeat (3) lookup_step(6'h03, 1'b1, !exp_err);
    chk1("dup_error_sticky", load_error, exp_err);

    // Random permutations with random lookup traffic
    repeat (2) begin
      do_restart(1'b1);
      shuffle_table();
      build_model();
      load_range(1'b1, 0, N);
      check_complete("rand");
      repeat (40) lookup_step(W'($urandom), bit'($urandom_range(1, 0)), 1'b1);
    end

    // Reset one cycle after a lookup, with another lookup in flight
    lookup_step(6'h10, 1'b1, 1'b1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sym   = 6'h10;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk1("midrst_ovld",  out_valid,  1'b0);
    chk1("midrst_ready", load_ready, 1'b1);
    chkw("midrst_out",   out_sym,    '0);
    chk1("midrst_done",  load_done,  1'b0);
    chk1("midrst_error", load_error, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/odo_sbox_inv_loader.md
# odo_sbox_inv_loader

Runtime-loadable inverse 6-bit S-box for the Odo hashing pipeline. It accepts a forward S-box table streamed in index order and builds the inverse table on the fly. It checks that the table is a bijection, then serves registered inverse lookups with the same one-cycle latency as the forward S-box. It sits on the unmix/verify side of the core, paired with the forward small S-boxes, so a table reconfiguration needs no resynthesis.

## Interface
- `W`, default 6: symbol width; table depth is 2^W entries. Only 6 is verified.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `restart`  in  1  single-cycle pulse that discards the table and returns to LOAD.
- `load_valid`  in  1  load entry present.
- `load_data`  in  W  forward-table value for the current index.
- `load_ready`  out  1  block accepts a load entry (high only in LOAD).
- `load_done`  out  1  one-cycle pulse when the table is complete and valid.
- `load_error`  out  1  sticky flag: the loaded table is not a bijection.
- `in_valid`  in  1  lookup request.
- `in`  in  W  symbol to invert.
- `out_valid`  out  1  lookup result valid.
- `out`  out  W  inverse-table result.

## Operation
- The table memory is 2^W × W (`inv`), plus a 2^W-bit `seen` bitmap and a W+1-bit entry counter `idx`.
- States:
  - LOAD (after reset and after `restart`).
  - READY.
  - ERR.
- Transitions:
  - LOAD: an entry is accepted when `load_valid && load_ready`. The accept writes `inv[load_data] <= idx[W-1:0]`, sets `seen[load_data]`, and increments `idx`.
  - Duplicate value: if `seen[load_data]` is already set on accept, set an internal `dup` flag.
  - Completion: the accept with `idx == 2^W-1` is the final accept. It goes to READY if no duplicate occurred (including on this accept), otherwise to ERR.
  - READY: lookups are serviced; load entries are not accepted.
  - ERR: lookups are ignored. Only `restart` or `rst` leaves ERR.
- `restart` (any state):
  - Clears `idx`, `seen` and `dup`, clears `load_error`, and enters LOAD.
  - A same-cycle load accept is discarded.
  - A same-cycle lookup produces no result.
- `inv` contents are not cleared by `restart` or `rst`. They are only valid in READY.
- Lookup in READY: the result is `out <= inv[in]` with `out_valid <= 1`.
- `in_valid` in LOAD or ERR: `out_valid <= 0` and `out` holds its value.
- There is no backpressure on lookups. One lookup can be issued per cycle.

## Timing
- Reset values:
  - State LOAD, so `load_ready`=1.
  - `load_done`=0, `load_error`=0, `out_valid`=0, `out`=0.
  - `idx`=0, `seen`=0.
- `load_ready` is a combinational decode of state: 1 exactly while in LOAD.
- Accepted entries: a full table takes exactly 64 accepts. `load_valid` gaps stall without effect.
- `load_done` pulses in the cycle after the final accept, the same cycle the state reads READY.
- `load_error` rises in the cycle after the final accept. It stays high until `restart` or `rst`.
- The earliest lookup is the cycle after the final accept. Its result appears one cycle later.
- Lookup latency is 1 cycle: `in_valid`/`in` sampled at edge N gives `out_valid`/`out` at edge N+1. Back-to-back lookups give back-to-back results.
- Reset mid-load or mid-lookup: the next cycle shows reset values. `out_valid` from an in-flight lookup is suppressed.
- `rst` has priority over `restart`, and `restart` has priority over all other inputs.

## Configuration
- `ODO_SBOX_INV_CHECK_EN` defined:
  - The `seen` bitmap and `dup` logic are built.
  - A non-bijective table ends in ERR with `load_error`=1.
- Not defined:
  - No bitmap is built and `load_error` is tied 0.
  - The final accept always goes to READY with a `load_done` pulse.
  - On duplicate values the later index wins in `inv`; unreached `inv` entries are stale.

## Test plan
- Identity table (entry i = i), 64 consecutive accepts: `load_done` is high the cycle after accept 63. Lookup `in`=0x2A gives `out`=0x2A, `out_valid`=1 one cycle later.
- Table entry i = i^0x15 loaded with random `load_valid` gaps: lookups 0x00, 0x3F, 0x15 issued back-to-back return 0x15, 0x2A, 0x00 on three consecutive cycles.
- Identity table except entry 5 = 0x03 (duplicate of entry 3), with CHECK_EN defined:
  - After accept 63, `load_error`=1, `load_done`=0, state ERR.
  - `in_valid` with `in`=0x03 never raises `out_valid`.
- Same duplicate table without CHECK_EN: `load_done` pulses and lookup 0x03 returns 0x05.
- `restart` after 10 accepts of identity:
  - `load_ready` stays 1 and the next 64 accepts of the i^0x15 table are required.
  - `load_done` pulses only after the 64th; lookup 0x00 returns 0x15.
- In READY, issue lookup 0x10 and assert `rst` the next cycle: `out_valid`=0 after reset, `load_ready`=1, `out`=0.
